// File: rtl/acc_pkg.sv
// Shared types for the accelerator predecoder: per-entry match descriptors and
// the predecode response record.
package acc_pkg;

    localparam int unsigned NumRs   = 3;
    localparam int unsigned WbWidth = 2;

    typedef struct packed {
        logic               accept;
        logic [WbWidth-1:0] writeback;
        logic               is_mem_op;
        logic [NumRs-1:0]   use_rs;
    } acc_prd_rsp_t;

    typedef struct packed {
        logic [31:0]  instr_data;
        logic [31:0]  instr_mask;
        acc_prd_rsp_t prd_rsp;
    } offload_instr_t;

endpackage

// File: rtl/acc_prd_bus.sv
// Request/response bus carrying instruction words into the predecoder and
// predecode responses back out.
interface ACC_PRD_BUS #(
    parameter int unsigned IdWidth = 4
);
    import acc_pkg::*;

    logic               q_valid;
    logic               q_ready;
    logic [31:0]        q_instr_data;
    logic [IdWidth-1:0] q_id;
    logic               p_valid;
    logic               p_ready;
    acc_prd_rsp_t       p_rsp;
    logic [IdWidth-1:0] p_id;
    logic               p_multi;

    modport master (
        output q_valid, q_instr_data, q_id, p_ready,
        input  q_ready, p_valid, p_rsp, p_id, p_multi
    );

    modport slave (
        input  q_valid, q_instr_data, q_id, p_ready,
        output q_ready, p_valid, p_rsp, p_id, p_multi
    );

endinterface

// File: rtl/acc_prd_match.sv
// Combinational match of an instruction word against the offload table; the
// responses of all hitting entries are OR-merged.
module acc_prd_match
    import acc_pkg::*;
#(
    parameter int unsigned                    NumInstr     = 1,
    parameter offload_instr_t [NumInstr-1:0] OffloadInstr = '0
) (
    input  logic [NumInstr-1:0] instr_en_i,
    input  logic [31:0]         instr_data_i,
    output acc_prd_rsp_t        rsp_o,
    output logic                multi_o
);

    logic [NumInstr-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(NumInstr); i++) begin
            hit[i] = instr_en_i[i] &&
                     ((OffloadInstr[i].instr_mask & instr_data_i) == OffloadInstr[i].instr_data);
        end
    end

    // The entry's own accept bit is ignored: accept means "some entry hit".
    always_comb begin
        logic seen;
        rsp_o   = '0;
        multi_o = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < int'(NumInstr); i++) begin
            if (hit[i]) begin
                rsp_o.writeback = rsp_o.writeback | OffloadInstr[i].prd_rsp.writeback;
                rsp_o.is_mem_op = rsp_o.is_mem_op | OffloadInstr[i].prd_rsp.is_mem_op;
                rsp_o.use_rs    = rsp_o.use_rs    | OffloadInstr[i].prd_rsp.use_rs;
                multi_o         = multi_o | seen;
                seen            = 1'b1;
            end
        end
        rsp_o.accept = |hit;
    end

endmodule

// File: rtl/acc_predecoder_pipe_intf.sv
// ACC_PRD_BUS wrapper around acc_predecoder_pipe.
module acc_predecoder_pipe_intf
    import acc_pkg::*;
#(
    parameter int unsigned                    NumInstr     = 1,
    parameter offload_instr_t [NumInstr-1:0] OffloadInstr = '0,
    parameter int unsigned                    IdWidth      = 4,
    parameter bit                             Registered   = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [NumInstr-1:0] instr_en_i,
    ACC_PRD_BUS.slave           bus,
    output logic [15:0]         acc_cnt_o,
    output logic [15:0]         rej_cnt_o
);

    acc_predecoder_pipe #(
        .NumInstr     (NumInstr),
        .OffloadInstr (OffloadInstr),
        .IdWidth      (IdWidth),
        .Registered   (Registered)
    ) u_pipe (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .instr_en_i     (instr_en_i),
        .q_valid_i      (bus.q_valid),
        .q_ready_o      (bus.q_ready),
        .q_instr_data_i (bus.q_instr_data),
        .q_id_i         (bus.q_id),
        .p_valid_o      (bus.p_valid),
        .p_ready_i      (bus.p_ready),
        .p_rsp_o        (bus.p_rsp),
        .p_id_o         (bus.p_id),
        .p_multi_o      (bus.p_multi),
        .acc_cnt_o      (acc_cnt_o),
        .rej_cnt_o      (rej_cnt_o)
    );

endmodule

// File: rtl/acc_predecoder_pipe.sv
// Accelerator predecoder with an optional single-entry output register and
// saturating accept/reject counters.
module acc_predecoder_pipe
    import acc_pkg::*;
#(
    parameter int unsigned                    NumInstr     = 1,
    parameter offload_instr_t [NumInstr-1:0] OffloadInstr = '0,
    parameter int unsigned                    IdWidth      = 4,
    parameter bit                             Registered   = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [NumInstr-1:0] instr_en_i,
    input  logic               q_valid_i,
    output logic               q_ready_o,
    input  logic [31:0]        q_instr_data_i,
    input  logic [IdWidth-1:0] q_id_i,
    output logic               p_valid_o,
    input  logic               p_ready_i,
    output acc_prd_rsp_t       p_rsp_o,
    output logic [IdWidth-1:0] p_id_o,
    output logic               p_multi_o,
    output logic [15:0]        acc_cnt_o,
    output logic [15:0]        rej_cnt_o
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; valid never waits on ready, and payload is held while valid & !ready.
    acc_prd_rsp_t match_rsp;
    logic         match_multi;
    logic         req_hs;

    acc_prd_match #(
        .NumInstr     (NumInstr),
        .OffloadInstr (OffloadInstr)
    ) u_match (
        .instr_en_i   (instr_en_i),
        .instr_data_i (q_instr_data_i),
        .rsp_o        (match_rsp),
        .multi_o      (match_multi)
    );

    assign req_hs = q_valid_i & q_ready_o;

    if (Registered) begin : g_reg
        logic               valid_q;
        acc_prd_rsp_t       rsp_q;
        logic [IdWidth-1:0] id_q;
        logic               multi_q;

        assign q_ready_o = (!valid_q || p_ready_i) && !flush_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end else if (req_hs) begin
                valid_q <= 1'b1;
            end else if (p_ready_i) begin
                valid_q <= 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rsp_q   <= '0;
                id_q    <= '0;
                multi_q <= 1'b0;
            end else if (req_hs) begin
                rsp_q   <= match_rsp;
                id_q    <= q_id_i;
                multi_q <= match_multi;
            end
        end

        assign p_valid_o = valid_q;
        assign p_rsp_o   = rsp_q;
        assign p_id_o    = id_q;
        assign p_multi_o = multi_q;
    end else begin : g_comb
        logic unused_flush;
        assign unused_flush = flush_i;

        // Outputs are forced quiet while reset is held.
        assign q_ready_o = p_ready_i;
        assign p_valid_o = q_valid_i & rst_ni;
        assign p_rsp_o   = rst_ni ? match_rsp : '0;
        assign p_id_o    = rst_ni ? q_id_i : '0;
        assign p_multi_o = match_multi & rst_ni;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_cnt_o <= '0;
            rej_cnt_o <= '0;
        end else if (req_hs) begin
            if (match_rsp.accept) begin
                if (acc_cnt_o != 16'hFFFF) acc_cnt_o <= acc_cnt_o + 16'd1;
            end else begin
                if (rej_cnt_o != 16'hFFFF) rej_cnt_o <= rej_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: doc/acc_predecoder_pipe.md
ACC_PREDECODER_PIPE -- requirements
Module: acc_predecoder_pipe

Interface
REQ-001 SHALL have parameter NumInstr, default 1: number of offloadable instruction entries; must be >= 1.
REQ-002 SHALL have parameter OffloadInstr, default one all-zero entry: array of NumInstr acc_pkg::offload_instr_t, each with instr_data, instr_mask and prd_rsp.
REQ-003 SHALL have parameter IdWidth, default 4: width of the instruction tag.
REQ-004 SHALL have parameter Registered, default 1: 1 = one output register stage; 0 = combinational pass-through.
REQ-005 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush_i  input  1  synchronous flush of the pending response.
REQ-008 SHALL have port instr_en_i  input  NumInstr  runtime enable per entry.
REQ-009 SHALL have port q_valid_i  input  1  request valid.
REQ-010 SHALL have port q_ready_o  output  1  request ready.
REQ-011 SHALL have port q_instr_data_i  input  32  instruction word.
REQ-012 SHALL have port q_id_i  input  IdWidth  request tag.
REQ-013 SHALL have port p_valid_o  output  1  response valid.
REQ-014 SHALL have port p_ready_i  input  1  response ready.
REQ-015 SHALL have port p_rsp_o  output  acc_pkg::acc_prd_rsp_t  response: p_accept, p_writeback[1:0], p_is_mem_op, p_use_rs[NumRs-1:0].
REQ-016 SHALL have port p_id_o  output  IdWidth  tag echoed from the request.
REQ-017 SHALL have port p_multi_o  output  1  more than one enabled entry matched.
REQ-018 SHALL have ports acc_cnt_o and rej_cnt_o  output  16 each  accepted and rejected request counters.

Function
REQ-019 SHALL compute hit[i] = instr_en_i[i] AND ((OffloadInstr[i].instr_mask & q_instr_data_i) == OffloadInstr[i].instr_data).
REQ-020 SHALL form the response as follows: p_accept = OR of hit; each other response field = bitwise OR of the prd_rsp fields of all hit entries; all fields are zero when no entry hits.
REQ-021 SHALL set p_multi = 1 when popcount(hit) >= 2; the OR-merged fields are still returned in that case.
REQ-022 SHALL define a request handshake as q_valid_i & q_ready_o, and a response handshake as p_valid_o & p_ready_i.
REQ-023 With Registered=1, SHALL drive q_ready_o = (!p_valid_o | p_ready_i) & !flush_i, giving a full-throughput single-entry pipeline with latency 1 cycle.
REQ-024 With Registered=1, on a request handshake SHALL load p_rsp, p_id and p_multi and set p_valid_o next cycle.
REQ-025 With Registered=1, on a response handshake with no request handshake SHALL clear p_valid_o next cycle.
REQ-026 With Registered=1, while p_valid_o=1 and p_ready_i=0 SHALL hold p_rsp_o, p_id_o and p_multi_o stable.
REQ-027 With Registered=1, flush_i=1 SHALL clear p_valid_o next cycle regardless of p_ready_i; the flushed response is not counted again.
REQ-028 With Registered=0, SHALL drive p_valid_o = q_valid_i and q_ready_o = p_ready_i, with outputs combinational from the inputs; flush_i is ignored.
REQ-029 SHALL increment acc_cnt_o on each request handshake with p_accept=1.
REQ-030 SHALL increment rej_cnt_o on each request handshake with p_accept=0.
REQ-031 SHALL saturate both counters at 0xFFFF with no wrap-around.
REQ-032 SHALL never assert p_valid_o without a preceding accepted request.

Reset
REQ-033 When rst_ni=0, SHALL asynchronously clear: p_valid_o=0, p_rsp_o=0, p_id_o=0, p_multi_o=0, acc_cnt_o=0, rej_cnt_o=0.
REQ-034 Reset mid-transaction SHALL drop the pending response; after release q_ready_o=1 when flush_i=0.

Structure
REQ-035 acc_pkg SHALL hold offload_instr_t, acc_prd_rsp_t, NumRs (=3) and the writeback width (=2); the module SHALL add no new package.
REQ-036 The match-and-merge logic SHALL be a sub-module acc_prd_match (combinational, NumInstr/OffloadInstr parameters), instantiated once.
REQ-037 An interface wrapper acc_predecoder_pipe_intf over ACC_PRD_BUS SHALL be provided.

Verification
Test configuration: entry0 mask 0x0000707F, data 0x0000002B, writeback 01, use_rs 011; entry1 mask 0x0000007F, data 0x0000002B, is_mem_op 1, use_rs 100.
REQ-038 instr 0x0000102B, id 3, en=11, p_ready=1 -> next cycle p_valid=1, accept=1, is_mem_op=1, use_rs=100, id=3, multi=0, acc_cnt=1.
REQ-039 instr 0x0000002B, en=11 -> accept=1, writeback=01, use_rs=111, is_mem_op=1, multi=1.
REQ-040 instr 0x00000033 -> accept=0, all fields 0, rej_cnt increments by 1.
REQ-041 Back-to-back valid for 4 cycles with p_ready=0 in cycle 2 -> q_ready=0 during that stall, output held stable, all 4 responses delivered in order with ids 0..3.
REQ-042 Pending response with p_ready=0, then flush_i=1 -> p_valid=0 next cycle, counters unchanged; separately, 0x10000 accepts -> acc_cnt stays 0xFFFF.
REQ-043 Async reset asserted mid-stall -> all outputs 0 immediately; with Registered=0, p_valid_o follows q_valid_i in the same cycle.
